mem_axi_bridge: RTL
===================

MEM_AXI_BRIDGE -- requirements
Module: mem_axi_bridge

Interface
REQ-001 SHALL have no parameters; all widths fixed: addr/data 32, strobe 4, resp 2.
REQ-002 Ports SHALL be exactly as listed in REQ-003 to REQ-011, in that order.
REQ-003 clk  input  1  sole clock, rising edge; rst  input  1  reset, asynchronous, active-high.
REQ-004 request_enable  input  1  single-cycle request pulse from the memory stage; mode  input  1  0=MEMREQ_READ, 1=MEMREQ_WRITE.
REQ-005 addr  input  32  word-aligned byte address; wdata  input  32  store data; wstrb  input  4  byte enables.
REQ-006 response_enable  output  1  single-cycle completion pulse to the memory stage.
REQ-007 data  output  32  read data; held until the next response.
REQ-008 AXI4-Lite write address channel: m_awaddr  output  32; m_awvalid  output  1; m_awready  input  1.
REQ-009 AXI4-Lite write data and response channels: m_wdata  output  32; m_wstrb  output  4; m_wvalid  output  1; m_wready  input  1; m_bresp  input  2; m_bvalid  input  1; m_bready  output  1.
REQ-010 AXI4-Lite read channels: m_araddr  output  32; m_arvalid  output  1; m_arready  input  1; m_rdata  input  32; m_rresp  input  2; m_rvalid  input  1; m_rready  output  1.
REQ-011 bus_error  output  1  pulses together with response_enable when the response was not OKAY.

Function
REQ-012 FSM states SHALL be exactly: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; every output SHALL be registered.
REQ-013 IDLE + request_enable=1 SHALL latch addr/wdata/wstrb; mode=0 -> RD_ADDR with m_arvalid=1 next cycle; mode=1 -> WR_REQ with m_awvalid=m_wvalid=1 next cycle.
REQ-014 request_enable in any state other than IDLE SHALL be ignored; no queueing.
REQ-015 RD_ADDR: m_arvalid SHALL stay high, m_araddr stable, until m_arvalid&m_arready; next state RD_DATA with m_arvalid=0, m_rready=1.
REQ-016 RD_DATA: on m_rvalid&m_rready, data<=m_rdata, response_enable=1 for one cycle, m_rready=0, next state IDLE.
REQ-017 WR_REQ: m_awvalid and m_wvalid SHALL each drop on their own handshake, independently, in any order or in the same cycle; when both are complete -> WR_RESP with m_bready=1.
REQ-018 WR_RESP: on m_bvalid&m_bready, response_enable=1 for one cycle, m_bready=0, data unchanged, next state IDLE.
REQ-019 Minimum latency with ready/valid always high SHALL be 3 cycles from the request_enable edge to the response_enable edge, for both reads and writes.
REQ-020 A valid SHALL never be withdrawn before its handshake; address and data SHALL never change while their valid is high.
REQ-021 A new request SHALL be accepted in the cycle after response_enable, i.e. back-to-back operation.

Reset
REQ-022 rst=1 SHALL asynchronously force: state=IDLE; all m_*valid, m_*ready, response_enable and bus_error 0; data, m_awaddr, m_araddr, m_wdata 0; m_wstrb 0.
REQ-023 Reset mid-transaction SHALL abort the transaction with no response_enable pulse; any AXI beat that arrives later SHALL be ignored while in IDLE.

Configuration
REQ-024 Macro MEM_AXI_BRIDGE_RESP_ERR_EN defined: bus_error=1 in the response_enable cycle when the matching m_rresp or m_bresp != 2'b00; the read still updates data.
REQ-025 Macro MEM_AXI_BRIDGE_RESP_ERR_EN undefined: bus_error SHALL be tied 0 and the resp inputs ignored; the port SHALL remain present.

Verification
REQ-026 Read: request addr=0x1000, mode=0; slave arready=1, rdata=0xDEADBEEF, rresp=0 -> m_araddr=0x1000, response_enable 3 cycles after request, data=0xDEADBEEF.
REQ-027 Write, split channels: addr=0x2004, wdata=0x12345678, wstrb=4'b0011; wready 4 cycles before awready, bvalid 2 cycles later -> each valid held until its own handshake, m_bready only after both, exactly one response_enable.
REQ-028 Backpressure: arready low for 5 cycles -> m_arvalid/m_araddr stable for all 5 cycles; a spurious request_enable in RD_DATA is ignored.
REQ-029 Errors: rresp=2'b10 -> bus_error=1 with response_enable when MEM_AXI_BRIDGE_RESP_ERR_EN is defined, bus_error=0 when it is not.
REQ-030 Reset: rst pulsed during WR_RESP -> outputs go 0 immediately, no response_enable; a following read of 0x3000 completes normally.

Source files
------------

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: single-outstanding memory-stage request to AXI4-Lite master bridge.
// Define MEM_AXI_BRIDGE_RESP_ERR_EN to report non-OKAY responses on bus_error.
module mem_axi_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        request_enable,
    input  logic        mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        response_enable,
    output logic [31:0] data,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic        bus_error
);
    localparam logic [2:0] IDLE = 3'd0, RD_ADDR = 3'd1, RD_DATA = 3'd2, WR_REQ = 3'd3, WR_RESP = 3'd4;
    logic [2:0] state;
    logic aw_left, w_left, rerr, berr;
    // a write channel stays pending until its own handshake completes
    assign aw_left = m_awvalid & ~m_awready;
    assign w_left  = m_wvalid & ~m_wready;
`ifdef MEM_AXI_BRIDGE_RESP_ERR_EN
    assign rerr = |m_rresp;
    assign berr = |m_bresp;
`else
    logic unused_resp;
    assign unused_resp = ^{m_rresp, m_bresp};
    assign rerr = 1'b0;
    assign berr = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            response_enable <= 1'b0;
            bus_error       <= 1'b0;
            data            <= '0;
            m_awaddr        <= '0;
            m_araddr        <= '0;
            m_wdata         <= '0;
            m_wstrb         <= '0;
            m_awvalid       <= 1'b0;
            m_wvalid        <= 1'b0;
            m_bready        <= 1'b0;
            m_arvalid       <= 1'b0;
            m_rready        <= 1'b0;
        end else begin
            response_enable <= 1'b0;
            bus_error       <= 1'b0;
            case (state)
                IDLE: if (request_enable) begin
                    m_awaddr <= addr;
                    m_araddr <= addr;
                    m_wdata  <= wdata;
                    m_wstrb  <= wstrb;
                    if (mode) begin
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        state     <= WR_REQ;
                    end else begin
                        m_arvalid <= 1'b1;
                        state     <= RD_ADDR;
                    end
                end
                RD_ADDR: if (m_arready) begin
                    m_arvalid <= 1'b0;
                    m_rready  <= 1'b1;
                    state     <= RD_DATA;
                end
                RD_DATA: if (m_rvalid) begin
                    data            <= m_rdata;
                    response_enable <= 1'b1;
                    bus_error       <= rerr;
                    m_rready        <= 1'b0;
                    state           <= IDLE;
                end
                WR_REQ: begin
                    m_awvalid <= aw_left;
                    m_wvalid  <= w_left;
                    if (!aw_left && !w_left) begin
                        m_bready <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: if (m_bvalid) begin
                    response_enable <= 1'b1;
                    bus_error       <= berr;
                    m_bready        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
